// File: rtl/score_keeper_if.sv
// Collision/restart inputs and score/status outputs of the snake-game score keeper.
// The master drives the game events; the slave (score_keeper) reports the score state.
interface score_keeper_if #(
  parameter int WIDTH = 7
);
  logic             goodColl;
  logic             badColl;
  logic             newGame;
  logic [WIDTH-1:0] dispScore;
  logic [WIDTH-1:0] highScore;
  logic [3:0]       livesLeft;
  logic             isGameComplete;
  logic             isGameWon;

  modport master (
    output goodColl, badColl, newGame,
    input  dispScore, highScore, livesLeft, isGameComplete, isGameWon
  );

  modport slave (
    input  goodColl, badColl, newGame,
    output dispScore, highScore, livesLeft, isGameComplete, isGameWon
  );
endinterface

// File: rtl/score_keeper.sv
// Snake-game score keeper: edge-detected collision/restart events drive a PLAY/OVER/WIN
// FSM that tracks the current score, remaining lives and the best final score since reset.
module score_keeper #(
  parameter int WIDTH     = 7,
  parameter int WIN_SCORE = 99,
  parameter int LIVES     = 1
) (
  input logic           clk,
  input logic           nRst,
  score_keeper_if.slave sk
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_OVER = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] WIN_C   = WIDTH'(WIN_SCORE);
  localparam logic [3:0]       LIVES_C = 4'(LIVES);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] score_r, score_nxt_s, score_inc_s;
  logic [WIDTH-1:0] high_r, high_nxt_s;
  logic [3:0]       lives_r, lives_nxt_s;
  logic             complete_r, won_r;
  logic             good_r, bad_r, new_r, arm_r;
  logic             good_ev_s, bad_ev_s, new_ev_s;

  // arm_r masks the first clock after reset so levels already high at release never count
  assign good_ev_s   = sk.goodColl & ~good_r & arm_r;
  assign bad_ev_s    = sk.badColl  & ~bad_r  & arm_r;
  assign new_ev_s    = sk.newGame  & ~new_r  & arm_r;
  assign score_inc_s = score_r + {{(WIDTH-1){1'b0}}, 1'b1};

  // Input history for rising-edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      good_r <= 1'b0;
      bad_r  <= 1'b0;
      new_r  <= 1'b0;
      arm_r  <= 1'b0;
    end else begin
      good_r <= sk.goodColl;
      bad_r  <= sk.badColl;
      new_r  <= sk.newGame;
      arm_r  <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= ST_PLAY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; restart beats everything, a bad hit beats an apple
  always_comb begin
    state_nxt_s = state_r;
    if (new_ev_s) begin
      state_nxt_s = ST_PLAY;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (bad_ev_s) begin
            state_nxt_s = (lives_r > 4'd1) ? ST_PLAY : ST_OVER;
          end else if (good_ev_s && (score_inc_s == WIN_C)) begin
            state_nxt_s = ST_WIN;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
        ST_OVER, ST_WIN: begin
          if (good_ev_s) begin
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = ST_PLAY;
      endcase
    end
  end

  // FSM output logic: next values of score, lives and high score
  always_comb begin
    score_nxt_s = score_r;
    lives_nxt_s = lives_r;
    high_nxt_s  = high_r;
    if (new_ev_s) begin
      score_nxt_s = {WIDTH{1'b0}};
      lives_nxt_s = LIVES_C;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (bad_ev_s) begin
            if (lives_r > 4'd1) begin
              lives_nxt_s = lives_r - 4'd1;
            end else begin
              lives_nxt_s = 4'd0;
              high_nxt_s  = (score_r > high_r) ? score_r : high_r;
            end
          end else if (good_ev_s && (score_r != WIN_C)) begin
            score_nxt_s = score_inc_s;
            if ((score_inc_s == WIN_C) && (WIN_C > high_r)) begin
              high_nxt_s = WIN_C;
            end else begin
              high_nxt_s = high_r;
            end
          end else begin
            score_nxt_s = score_r;
          end
        end
        ST_OVER, ST_WIN: begin
          if (good_ev_s) begin
            score_nxt_s = {{(WIDTH-1){1'b0}}, 1'b1};
            lives_nxt_s = LIVES_C;
          end else begin
            score_nxt_s = score_r;
          end
        end
        default: begin
          score_nxt_s = {WIDTH{1'b0}};
          lives_nxt_s = LIVES_C;
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      score_r    <= {WIDTH{1'b0}};
      high_r     <= {WIDTH{1'b0}};
      lives_r    <= LIVES_C;
      complete_r <= 1'b0;
      won_r      <= 1'b0;
    end else begin
      score_r    <= score_nxt_s;
      high_r     <= high_nxt_s;
      lives_r    <= lives_nxt_s;
      complete_r <= (state_nxt_s != ST_PLAY);
      won_r      <= (state_nxt_s == ST_WIN);
    end
  end

  assign sk.dispScore      = score_r;
  assign sk.highScore      = high_r;
  assign sk.livesLeft      = lives_r;
  assign sk.isGameComplete = complete_r;
  assign sk.isGameWon      = won_r;

endmodule
